fsum_seq: RTL
=============

FSUM_SEQ -- requirements
Module: fsum_seq

Interface
REQ-001 SHALL provide parameter CNT_W, default 16: width of the element counter.
REQ-002 SHALL provide port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL provide port rstn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL provide port in_valid, input, 1: in_data/in_last valid.
REQ-005 SHALL provide port in_ready, output, 1: element accepted when in_valid && in_ready at a clk edge.
REQ-006 SHALL provide port in_data, input, 32: IEEE-754 single-precision addend.
REQ-007 SHALL provide port in_last, input, 1: marks the final element of a packet.
REQ-008 SHALL provide port add_x1, output, 32: first operand to the external combinational single-precision adder.
REQ-009 SHALL provide port add_x2, output, 32: second operand to the external adder.
REQ-010 SHALL provide port add_y, input, 32: adder result, valid in the same cycle as add_x1/add_x2.
REQ-011 SHALL provide port add_ovf, input, 1: adder overflow flag for the current add_y.
REQ-012 SHALL provide port out_valid, output, 1: packet result valid.
REQ-013 SHALL provide port out_ready, input, 1: result consumed when out_valid && out_ready at a clk edge.
REQ-014 SHALL provide port out_sum, output, 32: packet sum.
REQ-015 SHALL provide port out_ovf, output, 1: sticky OR of add_ovf across the packet.
REQ-016 SHALL provide port out_count, output, CNT_W: number of elements in the packet.

Function
REQ-017 SHALL implement three states: RUN, ADD, DONE.
REQ-018 SHALL hold registers acc[31:0], opnd[31:0], last_r, ovf_r, cnt[CNT_W-1:0].
REQ-019 SHALL drive add_x1 = acc and add_x2 = opnd combinationally in every state.
REQ-020 SHALL assert in_ready only in RUN, out_valid only in DONE.
REQ-021 RUN: on accept, opnd <= in_data, last_r <= in_last, next state ADD; otherwise remain in RUN.
REQ-022 ADD: acc <= add_y, ovf_r <= ovf_r | add_ovf, cnt <= cnt+1 saturating at all-ones; next state DONE if last_r, else RUN.
REQ-023 Throughput SHALL be one element per 2 cycles; the result SHALL appear with out_valid 1 cycle after the ADD cycle of the last element.
REQ-024 DONE: out_sum = acc, out_ovf = ovf_r, out_count = cnt, all held stable while out_valid && !out_ready.
REQ-025 DONE with out_ready = 1: next state RUN, acc <= 32'h00000000, ovf_r <= 0, cnt <= 0.
REQ-026 in_valid SHALL be ignored outside RUN; no element SHALL be accepted in the same cycle a result is consumed.
REQ-027 Accumulator seed SHALL be +0 (32'h00000000); a single-element packet therefore yields add_y of (+0 + element).
REQ-028 The block SHALL NOT inspect or modify add_y: NaN, Inf and zero-sign handling SHALL be exactly the external adder's.
REQ-029 cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap; accumulation continues after saturation.
REQ-030 in_last on the first element SHALL form a 1-element packet; there SHALL be no zero-element packet.

Reset
REQ-031 rstn low SHALL immediately force state RUN and clear acc, opnd, last_r, ovf_r and cnt to 0, regardless of clk.
REQ-032 During reset, outputs SHALL be in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_count=0, add_x1=0, add_x2=0.
REQ-033 Reset asserted mid-packet (state ADD or DONE) SHALL discard the partial sum; the first packet after release SHALL start from +0.

Verification
REQ-034 Send 0x3F800000, then 0x40000000 with last -> out_sum=0x40400000, out_count=2, out_ovf=0, out_valid 4 cycles after the first accept.
REQ-035 Send 0x7F7FFFFF, then 0x7F7FFFFF with last; the adder model raises add_ovf -> out_ovf=1, out_sum=0x7F800000, out_count=2.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_count stable, in_ready=0 throughout; out_ready=1 -> RUN next cycle with acc=0.
REQ-037 Send 0x80000000 alone with last -> out_sum=0x00000000, out_count=1.
REQ-038 Pulse rstn low during ADD of a 3-element packet, then send 0x40A00000 with last -> out_sum=0x40A00000, out_count=1, out_ovf=0.
REQ-039 With CNT_W=2, send 5 elements of 0x3F800000 -> out_count=3, out_sum=0x40A00000.

Source files
------------

// File: rtl/fsum_seq.sv
// Sequential single-precision packet summer driving an external
// combinational adder; one element every two cycles.
module fsum_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_x1,
  output logic [31:0]      add_x2,
  input  logic [31:0]      add_y,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      opnd_q, opnd_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      acc_q   <= '0;
      opnd_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (in_valid) begin
          opnd_d  = in_data;
          last_d  = in_last;
          state_d = ADD;
        end
      end
      ADD: begin
        acc_d = add_y;
        ovf_d = ovf_q | add_ovf;
        // Count saturates; the sum keeps accumulating past it.
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = last_q ? DONE : RUN;
      end
      DONE: begin
        if (out_ready) begin
          state_d = RUN;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign add_x1    = acc_q;
  assign add_x2    = opnd_q;
  assign in_ready  = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule
